pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Central pipeline controller for the 5-stage RV64 core (IF/ID/EX/MEM/WB).
- Merges per-stage stall requests into the shared stall[5:0] vector and sequences exception/mret redirects, including flush generation and drain of outstanding bus traffic.
- Keeps stall/flush performance counters and a stall-hang watchdog.
- Sits beside the stage modules; its stall, flush and new_pc outputs fan out to every stage and to PC generation.

Parameters:
- HANG_LIMIT, 1024: consecutive stalled cycles before hang_err is raised.
- HANG_W, 16: width of the watchdog counter; must hold HANG_LIMIT.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low. Clock is clk.
- stallreq_if  in  1  IF stage stall request (sram not ready).
- stallreq_id  in  1  ID stage stall request (load-use or CSR hazard).
- stallreq_ex  in  1  EX stall request (multi-cycle mul/div busy).
- stallreq_mem  in  1  MEM stall request (data sram wait).
- excp_req  in  1  exception detected in MEM; level, valid one cycle.
- excp_cause  in  64  mcause value for excp_req.
- excp_pc  in  64  pc of the faulting instruction.
- mret_req  in  1  mret committing in MEM.
- mtvec  in  64  current mtvec CSR.
- mepc  in  64  current mepc CSR.
- bus_busy  in  1  data bus transaction outstanding.
- stall  out  6  stall[0]=PC, [1]=IF/ID, [2]=ID/EX, [3]=EX/MEM, [4]=MEM/WB, [5]=WB.
- flush  out  1  flush of all pipeline registers.
- new_pc  out  64  redirect target; valid only when flush=1.
- trap_taken  out  1  one-cycle pulse on an exception redirect (not mret).
- trap_cause  out  64  latched cause for the CSR unit.
- trap_epc  out  64  latched epc for the CSR unit.
- stall_cnt  out  64  cycles with stall[0]=1.
- flush_cnt  out  32  number of flushes.
- hang_err  out  1  sticky watchdog error.

Behaviour:
- Reset values: every output is 0. State is IDLE. All latches and counters are 0.
- States are IDLE, DRAIN and FLUSH.
- Stall in IDLE with no redirect request: the highest stage requesting wins.
  - stallreq_mem gives 6'b011111.
  - else stallreq_ex gives 6'b001111.
  - else stallreq_id gives 6'b000111.
  - else stallreq_if gives 6'b000011.
  - else 6'b000000.
  - This is combinational, so it takes effect in the same cycle.
- IDLE with excp_req or mret_req (excp_req has priority when both are high):
  - Latch the target: for an exception, {mtvec[63:2],2'b00}; for mret, mepc.
  - For an exception, also latch trap_cause=excp_cause and trap_epc=excp_pc.
  - stall=6'b111111 in the request cycle.
  - Next state is DRAIN if bus_busy=1 in that cycle, else FLUSH.
- DRAIN:
  - stall=6'b111111, flush=0.
  - All new requests are ignored.
  - Go to FLUSH in the cycle after bus_busy is sampled 0.
- FLUSH (exactly one cycle):
  - flush=1, stall=6'b000000, new_pc=latched target.
  - trap_taken=1 only for an exception.
  - flush_cnt increments and wraps.
  - Requests in this cycle are ignored.
  - Next state is IDLE.
- Latency: an excp_req at cycle T with bus idle gives flush at T+1. With bus_busy, flush comes one cycle after the first idle sample.
- new_pc=0 whenever flush=0. trap_cause and trap_epc hold until the next exception.
- stall_cnt:
  - Increments each cycle with stall[0]=1, including DRAIN and the request cycle.
  - Saturates at all-ones.
- Watchdog:
  - Counts consecutive cycles with stall[0]=1 and clears on any cycle with stall[0]=0.
  - When the count reaches HANG_LIMIT, hang_err is set.
  - hang_err stays set until reset, and the counter saturates.
- Reset mid-DRAIN or mid-FLUSH: return to IDLE, clear all latches, and issue no flush.

Test Plan:
- Simultaneous stallreq_if=1, stallreq_ex=1 -> stall=6'b001111 in the same cycle; drop stallreq_ex -> 6'b000011.
- excp_req=1 with cause=64'd2, mtvec=64'h8000_0103, bus_busy=0 at T -> at T stall=6'h3F; at T+1 flush=1, new_pc=64'h8000_0100, trap_taken=1, trap_cause=2, flush_cnt=1.
- excp_req with bus_busy=1 held for 3 cycles -> DRAIN with stall=6'h3F throughout; flush one cycle after bus_busy is sampled 0; mret_req pulsed during DRAIN has no effect.
- excp_req and mret_req together, mepc=64'h8000_0200 -> exception path taken with new_pc from mtvec; then mret alone -> new_pc=64'h8000_0200, trap_taken=0.
- stallreq_mem held for HANG_LIMIT cycles -> hang_err=1 on cycle HANG_LIMIT and stays set after the request drops; stall_cnt=HANG_LIMIT.
- rst_n=0 during DRAIN -> next cycle all outputs 0, and no flush follows once bus_busy drops.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Central pipeline controller for the 5-stage RV64 core.
// Merges stage stall requests into one stall vector. Sequences exception and
// mret redirects through IDLE -> (DRAIN) -> FLUSH. Also keeps the stall and
// flush performance counters and a stall-hang watchdog.
module pipe_ctrl #(
  parameter int HANG_LIMIT = 1024,
  parameter int HANG_W     = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic        excp_req,
  input  logic [63:0] excp_cause,
  input  logic [63:0] excp_pc,
  input  logic        mret_req,
  input  logic [63:0] mtvec,
  input  logic [63:0] mepc,
  input  logic        bus_busy,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [63:0] new_pc,
  output logic        trap_taken,
  output logic [63:0] trap_cause,
  output logic [63:0] trap_epc,
  output logic [63:0] stall_cnt,
  output logic [31:0] flush_cnt,
  output logic        hang_err
);

  typedef enum logic [1:0] {IDLE, DRAIN, FLUSH} state_t;

  localparam logic [HANG_W-1:0] HANG_MAX = HANG_W'(HANG_LIMIT);

  state_t             state_q, state_d;
  logic [63:0]        target_q, target_d;
  logic               is_excp_q, is_excp_d;
  logic [63:0]        trap_cause_q, trap_cause_d;
  logic [63:0]        trap_epc_q, trap_epc_d;
  logic [63:0]        stall_cnt_q, stall_cnt_d;
  logic [31:0]        flush_cnt_q, flush_cnt_d;
  logic [HANG_W-1:0]  hang_cnt_q, hang_cnt_d;
  logic               hang_err_q, hang_err_d;
  logic [5:0]         stall_c;
  logic               flush_c;

  // Next-state logic, stall/flush generation and redirect target capture.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_d      = state_q;
    target_d     = target_q;
    is_excp_d    = is_excp_q;
    trap_cause_d = trap_cause_q;
    trap_epc_d   = trap_epc_q;
    stall_c      = 6'b000000;
    flush_c      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (excp_req) begin
          stall_c      = 6'b111111;
          target_d     = {mtvec[63:2], 2'b00};
          is_excp_d    = 1'b1;
          trap_cause_d = excp_cause;
          trap_epc_d   = excp_pc;
          state_d      = bus_busy ? DRAIN : FLUSH;
        end else if (mret_req) begin
          stall_c   = 6'b111111;
          target_d  = mepc;
          is_excp_d = 1'b0;
          state_d   = bus_busy ? DRAIN : FLUSH;
        end else if (stallreq_mem) begin
          stall_c = 6'b011111;
        end else if (stallreq_ex) begin
          stall_c = 6'b001111;
        end else if (stallreq_id) begin
          stall_c = 6'b000111;
        end else if (stallreq_if) begin
          stall_c = 6'b000011;
        end
      end
      DRAIN: begin
        stall_c = 6'b111111;
        if (!bus_busy) state_d = FLUSH;
      end
      FLUSH: begin
        flush_c = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Performance counters and watchdog next values.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_c[0] && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 64'd1;

    // Counted on entry so the value already includes the flush being signalled.
    flush_cnt_d = flush_cnt_q;
    if (state_d == FLUSH) flush_cnt_d = flush_cnt_q + 32'd1;

    hang_cnt_d = '0;
    if (stall_c[0]) hang_cnt_d = (hang_cnt_q != '1) ? hang_cnt_q + 1'b1 : hang_cnt_q;

    hang_err_d = hang_err_q | (hang_cnt_d >= HANG_MAX);
  end

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q      <= IDLE;
      target_q     <= '0;
      is_excp_q    <= 1'b0;
      trap_cause_q <= '0;
      trap_epc_q   <= '0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      hang_cnt_q   <= '0;
      hang_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      is_excp_q    <= is_excp_d;
      trap_cause_q <= trap_cause_d;
      trap_epc_q   <= trap_epc_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      hang_cnt_q   <= hang_cnt_d;
      hang_err_q   <= hang_err_d;
    end
  end

  assign stall      = stall_c;
  assign flush      = flush_c;
  assign new_pc     = flush_c ? target_q : 64'd0;
  assign trap_taken = flush_c & is_excp_q;
  assign trap_cause = trap_cause_q;
  assign trap_epc   = trap_epc_q;
  assign stall_cnt  = stall_cnt_q;
  assign flush_cnt  = flush_cnt_q;
  assign hang_err   = hang_err_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: table-driven stall priority vectors plus
// hand-written redirect, drain, reset and watchdog sequences.
module tb_pipe_ctrl;

  localparam int HANG_LIMIT = 1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
  logic        excp_req, mret_req, bus_busy;
  logic [63:0] excp_cause, excp_pc, mtvec, mepc;
  logic [5:0]  stall;
  logic        flush, trap_taken, hang_err;
  logic [63:0] new_pc, trap_cause, trap_epc, stall_cnt;
  logic [31:0] flush_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       r_if;
    logic       r_id;
    logic       r_ex;
    logic       r_mem;
    logic [5:0] exp_stall;
  } vec_t;

  vec_t vecs [10];

  pipe_ctrl #(.HANG_LIMIT(HANG_LIMIT), .HANG_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
    .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
    .excp_req(excp_req), .excp_cause(excp_cause), .excp_pc(excp_pc),
    .mret_req(mret_req), .mtvec(mtvec), .mepc(mepc), .bus_busy(bus_busy),
    .stall(stall), .flush(flush), .new_pc(new_pc), .trap_taken(trap_taken),
    .trap_cause(trap_cause), .trap_epc(trap_epc), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt), .hang_err(hang_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance one clock; inputs are then driven and outputs sampled mid-cycle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    longint exp_sc;

    rst_n = 1'b0;
    {stallreq_if, stallreq_id, stallreq_ex, stallreq_mem} = 4'b0000;
    {excp_req, mret_req, bus_busy} = 3'b000;
    excp_cause = 64'd0; excp_pc = 64'd0; mtvec = 64'd0; mepc = 64'd0;
    step(); step();
    rst_n = 1'b1;
    settle();
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_flush", 64'(flush), 64'd0);
    check("rst_new_pc", new_pc, 64'd0);
    check("rst_trap_taken", 64'(trap_taken), 64'd0);
    check("rst_trap_cause", trap_cause, 64'd0);
    check("rst_trap_epc", trap_epc, 64'd0);
    check("rst_stall_cnt", stall_cnt, 64'd0);
    check("rst_flush_cnt", 64'(flush_cnt), 64'd0);
    check("rst_hang_err", 64'(hang_err), 64'd0);

    // Stall priority table: {if, id, ex, mem, expected stall}.
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 6'b000000};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 6'b000011};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 6'b000111};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 6'b001111};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 6'b011111};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 6'b001111};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 6'b000011};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 6'b000111};
    vecs[8] = '{1'b1, 1'b1, 1'b1, 1'b1, 6'b011111};
    vecs[9] = '{1'b0, 1'b1, 1'b1, 1'b0, 6'b001111};

    exp_sc = 0;
    for (int i = 0; i < 10; i++) begin
      stallreq_if  = vecs[i].r_if;
      stallreq_id  = vecs[i].r_id;
      stallreq_ex  = vecs[i].r_ex;
      stallreq_mem = vecs[i].r_mem;
      settle();
      check($sformatf("vec%0d_stall", i), 64'(stall), 64'(vecs[i].exp_stall));
      check($sformatf("vec%0d_flush", i), 64'(flush), 64'd0);
      if (vecs[i].exp_stall[0]) exp_sc++;
      step();
    end
    {stallreq_if, stallreq_id, stallreq_ex, stallreq_mem} = 4'b0000;
    settle();
    check("tbl_stall_cnt", stall_cnt, 64'(exp_sc));

    // Exception with bus idle: flush in the next cycle.
    excp_req = 1'b1; excp_cause = 64'd2; excp_pc = 64'h8000_0040;
    mtvec = 64'h8000_0103; bus_busy = 1'b0;
    settle();
    check("exc_req_stall", 64'(stall), 64'h3F);
    check("exc_req_flush", 64'(flush), 64'd0);
    step();
    excp_req = 1'b0;
    settle();
    check("exc_flush", 64'(flush), 64'd1);
    check("exc_new_pc", new_pc, 64'h8000_0100);
    check("exc_trap_taken", 64'(trap_taken), 64'd1);
    check("exc_trap_cause", trap_cause, 64'd2);
    check("exc_trap_epc", trap_epc, 64'h8000_0040);
    check("exc_flush_cnt", 64'(flush_cnt), 64'd1);
    check("exc_flush_stall", 64'(stall), 64'd0);
    step();
    check("exc_after_flush", 64'(flush), 64'd0);
    check("exc_after_new_pc", new_pc, 64'd0);
    check("exc_after_taken", 64'(trap_taken), 64'd0);
    check("exc_cause_hold", trap_cause, 64'd2);

    // Exception with bus busy for three cycles; mret in DRAIN is ignored.
    excp_req = 1'b1; excp_cause = 64'd5; excp_pc = 64'h8000_0080;
    mepc = 64'h8000_0200; bus_busy = 1'b1;
    settle();
    check("drn_req_stall", 64'(stall), 64'h3F);
    step();
    excp_req = 1'b0; mret_req = 1'b1;
    settle();
    check("drn1_stall", 64'(stall), 64'h3F);
    check("drn1_flush", 64'(flush), 64'd0);
    step();
    mret_req = 1'b0;
    settle();
    check("drn2_stall", 64'(stall), 64'h3F);
    check("drn2_flush", 64'(flush), 64'd0);
    step();
    bus_busy = 1'b0;
    settle();
    check("drn3_stall", 64'(stall), 64'h3F);
    check("drn3_flush", 64'(flush), 64'd0);
    step();
    check("drn_flush", 64'(flush), 64'd1);
    check("drn_new_pc", new_pc, 64'h8000_0100);
    check("drn_trap_taken", 64'(trap_taken), 64'd1);
    check("drn_trap_cause", trap_cause, 64'd5);
    check("drn_flush_cnt", 64'(flush_cnt), 64'd2);
    step();
    check("drn_post_flush", 64'(flush), 64'd0);
    check("drn_post_stall", 64'(stall), 64'd0);
    step();
    check("drn_no_mret_flush", 64'(flush), 64'd0);
    check("drn_flush_cnt_hold", 64'(flush_cnt), 64'd2);

    // Simultaneous excp and mret: exception wins; then mret alone.
    excp_req = 1'b1; mret_req = 1'b1; excp_cause = 64'd7; excp_pc = 64'h8000_00C0;
    settle();
    step();
    excp_req = 1'b0; mret_req = 1'b0;
    settle();
    check("both_flush", 64'(flush), 64'd1);
    check("both_new_pc", new_pc, 64'h8000_0100);
    check("both_trap_taken", 64'(trap_taken), 64'd1);
    check("both_trap_cause", trap_cause, 64'd7);
    step();
    mret_req = 1'b1;
    settle();
    check("mret_req_stall", 64'(stall), 64'h3F);
    step();
    mret_req = 1'b0;
    settle();
    check("mret_flush", 64'(flush), 64'd1);
    check("mret_new_pc", new_pc, 64'h8000_0200);
    check("mret_trap_taken", 64'(trap_taken), 64'd0);
    check("mret_cause_hold", trap_cause, 64'd7);
    check("mret_epc_hold", trap_epc, 64'h8000_00C0);
    check("mret_flush_cnt", 64'(flush_cnt), 64'd4);
    step();

    // Reset during DRAIN: everything clears and no flush follows.
    excp_req = 1'b1; excp_cause = 64'd9; bus_busy = 1'b1;
    settle();
    step();
    excp_req = 1'b0;
    settle();
    check("rstd_drain_stall", 64'(stall), 64'h3F);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    settle();
    check("rstd_stall", 64'(stall), 64'd0);
    check("rstd_flush", 64'(flush), 64'd0);
    check("rstd_new_pc", new_pc, 64'd0);
    check("rstd_trap_cause", trap_cause, 64'd0);
    check("rstd_trap_epc", trap_epc, 64'd0);
    check("rstd_stall_cnt", stall_cnt, 64'd0);
    check("rstd_flush_cnt", 64'(flush_cnt), 64'd0);
    bus_busy = 1'b0;
    step();
    check("rstd_no_flush1", 64'(flush), 64'd0);
    step();
    check("rstd_no_flush2", 64'(flush), 64'd0);
    check("rstd_flush_cnt2", 64'(flush_cnt), 64'd0);

    // Watchdog: stallreq_mem held for exactly HANG_LIMIT cycles.
    stallreq_mem = 1'b1;
    for (int i = 0; i < HANG_LIMIT - 1; i++) step();
    check("hang_before", 64'(hang_err), 64'd0);
    check("hang_cnt_before", stall_cnt, 64'(HANG_LIMIT - 1));
    step();
    check("hang_set", 64'(hang_err), 64'd1);
    check("hang_stall_cnt", stall_cnt, 64'(HANG_LIMIT));
    stallreq_mem = 1'b0;
    step();
    check("hang_sticky", 64'(hang_err), 64'd1);
    check("hang_stall_off", 64'(stall), 64'd0);
    check("hang_stall_cnt_hold", stall_cnt, 64'(HANG_LIMIT));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
